// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO command arbiter.
// Field widths, action codes, FSM states and the FIFO-stall predicate.
package pio_arb_pkg;

    localparam int unsigned ACT_W  = 4;
    localparam int unsigned MIDX_W = 2;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DAT_W  = 32;
    localparam int unsigned NSM    = 4;
    localparam int unsigned GID_W  = 2;

    localparam logic [ACT_W-1:0] ACT_NONE = 4'd0;
    localparam logic [ACT_W-1:0] ACT_PUSH = 4'd1;
    localparam logic [ACT_W-1:0] ACT_PULL = 4'd2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ISSUE,
        CAPT,
        RESP
    } arb_state_e;

    typedef struct packed {
        logic [ACT_W-1:0]  action;
        logic [MIDX_W-1:0] mindex;
        logic [IDX_W-1:0]  index;
        logic [DAT_W-1:0]  din;
    } pio_cmd_t;

    // A push needs room in the TX FIFO, a pull needs data in the RX FIFO.
    function automatic logic cmd_blocked(
        input pio_cmd_t         cmd,
        input logic [NSM-1:0]   tx_full,
        input logic [NSM-1:0]   rx_empty
    );
        return ((cmd.action == ACT_PUSH) && tx_full[cmd.mindex]) ||
               ((cmd.action == ACT_PULL) && rx_empty[cmd.mindex]);
    endfunction

endpackage

// File: rtl/pio_rr_arbiter.sv
// Combinational requester select: round-robin from ptr, or fixed priority
// (lowest index wins) when PIO_ARB_FIXED_PRIO_EN is defined.
module pio_rr_arbiter
    import pio_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [GID_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt_c,
    output logic [GID_W-1:0] gnt_idx_c
);

    logic [NREQ-1:0] req_hi;
    logic [NREQ-1:0] pool;

`ifdef PIO_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign req_hi     = '0;
`else
    // Requests at or above the pointer get first pick; otherwise wrap around.
    always_comb begin
        req_hi = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            req_hi[i] = req[i] && (GID_W'(i) >= ptr);
        end
    end
`endif

    assign pool = (|req_hi) ? req_hi : req;

    // Lowest set bit of the pool wins.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (pool[i]) begin
                gnt_c     = NREQ'(1) << i;
                gnt_idx_c = GID_W'(i);
            end
        end
    end

endmodule

// File: rtl/pio_cmd_arbiter.sv
// Shares one PIO command port between NREQ requesters, one command at a time,
// stalling push/pull on FIFO state. Optional macro: PIO_ARB_FIXED_PRIO_EN.
module pio_cmd_arbiter
    import pio_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [ACT_W*NREQ-1:0]   req_action_i,
    input  logic [MIDX_W*NREQ-1:0]  req_mindex_i,
    input  logic [IDX_W*NREQ-1:0]   req_index_i,
    input  logic [DAT_W*NREQ-1:0]   req_din_i,
    output logic [NREQ-1:0]         rsp_valid_o,
    output logic                    rsp_err_o,
    output logic [DAT_W-1:0]        rsp_dout_o,
    output logic [ACT_W-1:0]        pio_action_o,
    output logic [MIDX_W-1:0]       pio_mindex_o,
    output logic [IDX_W-1:0]        pio_index_o,
    output logic [DAT_W-1:0]        pio_din_o,
    input  logic [DAT_W-1:0]        pio_dout_i,
    input  logic [NSM-1:0]          tx_full_i,
    input  logic [NSM-1:0]          rx_empty_i
);

    localparam int unsigned WCNT_W = $clog2(WAIT_MAX + 1);

    arb_state_e        state, state_next;
    pio_cmd_t          cmd_q, cmd_d, sel_cmd;
    logic [GID_W-1:0]  gid_q, gid_d;
    logic [GID_W-1:0]  ptr_q, ptr_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic              blocked;

    logic [NREQ-1:0]   ready_d;
    logic [NREQ-1:0]   rsp_valid_d;
    logic              rsp_err_d;
    logic [DAT_W-1:0]  rsp_dout_d;
    logic [ACT_W-1:0]  action_d;

    logic [NREQ-1:0]   gnt_c;
    logic [GID_W-1:0]  gnt_idx_c;

    pio_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (req_valid_i),
        .ptr       (ptr_q),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c)
    );

    // Command fields of the granted requester.
    always_comb begin
        sel_cmd = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_c[i]) begin
                sel_cmd.action = req_action_i[i*ACT_W +: ACT_W];
                sel_cmd.mindex = req_mindex_i[i*MIDX_W +: MIDX_W];
                sel_cmd.index  = req_index_i[i*IDX_W +: IDX_W];
                sel_cmd.din    = req_din_i[i*DAT_W +: DAT_W];
            end
        end
    end

    assign blocked = cmd_blocked(cmd_q, tx_full_i, rx_empty_i);

    // Next-state and registered-output decode.
    always_comb begin
        state_next  = state;
        cmd_d       = cmd_q;
        gid_d       = gid_q;
        ptr_d       = ptr_q;
        wcnt_d      = wcnt_q;
        err_d       = err_q;
        ready_d     = '0;
        rsp_valid_d = '0;
        action_d    = ACT_NONE;
        rsp_err_d   = rsp_err_o;
        rsp_dout_d  = rsp_dout_o;

        unique case (state)
            IDLE: begin
                if (|req_valid_i) begin
                    ready_d    = gnt_c;
                    cmd_d      = sel_cmd;
                    gid_d      = gnt_idx_c;
                    err_d      = 1'b0;
`ifdef PIO_ARB_FIXED_PRIO_EN
                    ptr_d      = '0;
`else
                    ptr_d      = (gnt_idx_c == GID_W'(NREQ - 1)) ? '0 : gnt_idx_c + 1'b1;
`endif
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!blocked) begin
                    state_next = ISSUE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_d == WCNT_W'(WAIT_MAX)) begin
                        err_d      = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            ISSUE: begin
                action_d   = cmd_q.action;
                state_next = CAPT;
            end
            CAPT: begin
                state_next = RESP;
            end
            RESP: begin
                // PIO dout is valid the cycle after the strobe, which is this one.
                rsp_valid_d = NREQ'(1) << gid_q;
                rsp_err_d   = err_q;
                if (!err_q) begin
                    rsp_dout_d = pio_dout_i;
                end
                wcnt_d      = '0;
                cmd_d       = '0;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cmd_q        <= '0;
            gid_q        <= '0;
            ptr_q        <= '0;
            wcnt_q       <= '0;
            err_q        <= 1'b0;
            req_ready_o  <= '0;
            rsp_valid_o  <= '0;
            rsp_err_o    <= 1'b0;
            rsp_dout_o   <= '0;
            pio_action_o <= ACT_NONE;
        end else begin
            cmd_q        <= cmd_d;
            gid_q        <= gid_d;
            ptr_q        <= ptr_d;
            wcnt_q       <= wcnt_d;
            err_q        <= err_d;
            req_ready_o  <= ready_d;
            rsp_valid_o  <= rsp_valid_d;
            rsp_err_o    <= rsp_err_d;
            rsp_dout_o   <= rsp_dout_d;
            pio_action_o <= action_d;
        end
    end

    // Latched command drives the PIO fields from grant until RESP exits.
    assign pio_mindex_o = cmd_q.mindex;
    assign pio_index_o  = cmd_q.index;
    assign pio_din_o    = cmd_q.din;

endmodule

// File: tb/tb_pio_cmd_arbiter.sv
// Scoreboard bench for pio_cmd_arbiter: expected strobes/responses are queued
// when a command is set up and checked as the DUT emits them.
`timescale 1ns/1ps
module tb_pio_cmd_arbiter;
    import pio_arb_pkg::*;

    localparam int unsigned NREQ     = 2;
    localparam int unsigned WAIT_MAX = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [7:0]  req_action = '0;
    logic [3:0]  req_mindex = '0;
    logic [9:0]  req_index = '0;
    logic [63:0] req_din = '0;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_dout;
    logic [3:0]  pio_action;
    logic [1:0]  pio_mindex;
    logic [4:0]  pio_index;
    logic [31:0] pio_din;
    logic [31:0] pio_dout = '0;
    logic [3:0]  tx_full = '0;
    logic [3:0]  rx_empty = '0;

    always #5 clk = ~clk;

    pio_cmd_arbiter #(
        .NREQ     (NREQ),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_action_i (req_action),
        .req_mindex_i (req_mindex),
        .req_index_i  (req_index),
        .req_din_i    (req_din),
        .rsp_valid_o  (rsp_valid),
        .rsp_err_o    (rsp_err),
        .rsp_dout_o   (rsp_dout),
        .pio_action_o (pio_action),
        .pio_mindex_o (pio_mindex),
        .pio_index_o  (pio_index),
        .pio_din_o    (pio_din),
        .pio_dout_i   (pio_dout),
        .tx_full_i    (tx_full),
        .rx_empty_i   (rx_empty)
    );

    typedef struct {
        int          id;
        logic        err;
        bit          chk_dout;
        logic [31:0] dout;
    } rsp_exp_t;

    typedef struct {
        logic [3:0]  act;
        logic [1:0]  midx;
        logic [4:0]  idx;
        logic [31:0] din;
    } stb_exp_t;

    rsp_exp_t rsp_q[$];
    stb_exp_t stb_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ready_cnt = 0, stb_cnt = 0, rsp_cnt = 0;
    int last_ready_cyc = -100, last_stb_cyc = -100, last_rsp_cyc = -100;
    logic [1:0] last_ready = '0;
    int exp_ptr = 0;

    // Advance to the next falling edge and score whatever the DUT emitted.
    task automatic tick();
        stb_exp_t   se;
        rsp_exp_t   re;
        logic [1:0] want;
        @(negedge clk);
        cyc++;
        if (req_ready !== 2'b00) begin
            last_ready     = req_ready;
            last_ready_cyc = cyc;
            ready_cnt++;
        end
        if (pio_action !== 4'd0) begin
            stb_cnt++;
            last_stb_cyc = cyc;
            checks++;
            if (stb_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: cyc=%0d action=%0d, expected no strobe", cyc, pio_action);
            end else begin
                se = stb_q.pop_front();
                if (pio_action !== se.act || pio_mindex !== se.midx ||
                    pio_index !== se.idx || pio_din !== se.din) begin
                    errors++;
                    $display("FAIL strobe_fields: got act=%0d midx=%0d idx=%0d din=%h, expected act=%0d midx=%0d idx=%0d din=%h",
                             pio_action, pio_mindex, pio_index, pio_din, se.act, se.midx, se.idx, se.din);
                end
            end
        end
        if (rsp_valid !== 2'b00) begin
            rsp_cnt++;
            last_rsp_cyc = cyc;
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: cyc=%0d rsp_valid=%b, expected none", cyc, rsp_valid);
            end else begin
                re   = rsp_q.pop_front();
                want = 2'b01 << re.id;
                if (rsp_valid !== want || rsp_err !== re.err ||
                    (re.chk_dout && rsp_dout !== re.dout)) begin
                    errors++;
                    $display("FAIL rsp_fields: got valid=%b err=%b dout=%h, expected valid=%b err=%b dout=%h",
                             rsp_valid, rsp_err, rsp_dout, want, re.err, re.dout);
                end
            end
        end
    endtask

    task automatic set_req(input int r, input logic [3:0] act, input logic [1:0] midx,
                           input logic [4:0] idx, input logic [31:0] din);
        req_action[r*4 +: 4] = act;
        req_mindex[r*2 +: 2] = midx;
        req_index[r*5 +: 5]  = idx;
        req_din[r*32 +: 32]  = din;
    endtask

    task automatic expect_cmd(input int r, input logic [3:0] act, input logic [1:0] midx,
                              input logic [4:0] idx, input logic [31:0] din, input logic err,
                              input bit chk, input logic [31:0] dout, input bit stb);
        rsp_exp_t re;
        stb_exp_t se;
        re.id = r; re.err = err; re.chk_dout = chk; re.dout = dout;
        rsp_q.push_back(re);
        if (stb) begin
            se.act = act; se.midx = midx; se.idx = idx; se.din = din;
            stb_q.push_back(se);
        end
    endtask

    task automatic wait_ready(input int bound, output int n);
        int start;
        int k;
        start = ready_cnt;
        k = 0;
        while (ready_cnt == start && k < bound) begin
            tick();
            k++;
        end
        if (ready_cnt == start) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: no req_ready within %0d cycles", bound);
        end
        n = last_ready_cyc;
    endtask

    task automatic wait_rsp(input int bound);
        int start;
        int k;
        start = rsp_cnt;
        k = 0;
        while (rsp_cnt == start && k < bound) begin
            tick();
            k++;
        end
        if (rsp_cnt == start) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", bound);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_dout, pio_action, pio_mindex, pio_index, pio_din} !== 80'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b rsp=%b err=%b act=%0d din=%h, expected all 0",
                     req_ready, rsp_valid, rsp_err, pio_action, pio_din);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({req_ready, rsp_valid, pio_action} !== 8'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got ready=%b rsp=%b act=%0d, expected 0", req_ready, rsp_valid, pio_action);
        end
        exp_ptr = 0;
    endtask

    task automatic test_single_push();
        int n;
        pio_dout = 32'hA5A5_0001;
        set_req(0, ACT_PUSH, 2'd1, 5'd3, 32'hDEAD_BEEF);
        expect_cmd(0, ACT_PUSH, 2'd1, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1);
        last_stb_cyc = -100;
        req_valid = 2'b01;
        wait_ready(20, n);
        req_valid = 2'b00;
        set_req(0, ACT_PULL, 2'd0, 5'd0, 32'h0);
        checks++;
        if (last_ready !== 2'b01 || pio_din !== 32'hDEAD_BEEF || pio_action !== 4'd0) begin
            errors++;
            $display("FAIL single_accept: got ready=%b din=%h act=%0d, expected ready=01 din=deadbeef act=0",
                     last_ready, pio_din, pio_action);
        end
        exp_ptr = 1;
        wait_rsp(20);
        checks++;
        if (last_stb_cyc != n + 2 || last_rsp_cyc != n + 4) begin
            errors++;
            $display("FAIL single_latency: got strobe@+%0d rsp@+%0d, expected +2 and +4",
                     last_stb_cyc - n, last_rsp_cyc - n);
        end
    endtask

    task automatic test_pull_stall();
        int n;
        int s0;
        pio_dout = 32'h1234_5678;
        rx_empty = 4'b0100;
        set_req(1, ACT_PULL, 2'd2, 5'd7, 32'h0000_0042);
        expect_cmd(1, ACT_PULL, 2'd2, 5'd7, 32'h0000_0042, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
        req_valid = 2'b10;
        wait_ready(20, n);
        req_valid = 2'b00;
        s0 = stb_cnt;
        repeat (10) tick();
        checks++;
        if (stb_cnt != s0) begin
            errors++;
            $display("FAIL pull_stall_early: got %0d strobes while rx_empty, expected 0", stb_cnt - s0);
        end
        rx_empty = 4'b0000;
        wait_rsp(20);
        checks++;
        if (last_stb_cyc != n + 12 || last_rsp_cyc != n + 14) begin
            errors++;
            $display("FAIL pull_stall_latency: got strobe@+%0d rsp@+%0d, expected +12 and +14",
                     last_stb_cyc - n, last_rsp_cyc - n);
        end
        exp_ptr = 0;
    endtask

    task automatic test_timeout();
        int n;
        int s0;
        tx_full = 4'b1000;
        pio_dout = 32'hFFFF_0000;
        set_req(0, ACT_PUSH, 2'd3, 5'd1, 32'hCAFE_0000);
        expect_cmd(0, ACT_PUSH, 2'd3, 5'd1, 32'hCAFE_0000, 1'b1, 1'b0, 32'h0, 1'b0);
        s0 = stb_cnt;
        req_valid = 2'b01;
        wait_ready(20, n);
        req_valid = 2'b00;
        wait_rsp(WAIT_MAX + 40);
        checks++;
        if (last_rsp_cyc < n + int'(WAIT_MAX) || last_rsp_cyc > n + int'(WAIT_MAX) + 4 || stb_cnt != s0) begin
            errors++;
            $display("FAIL timeout_abort: got rsp@+%0d strobes=%0d, expected rsp@+%0d..+%0d strobes=0",
                     last_rsp_cyc - n, stb_cnt - s0, WAIT_MAX, WAIT_MAX + 4);
        end
        tick();
        tick();
        checks++;
        if (rsp_err !== 1'b1 || rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL err_hold: got err=%b valid=%b, expected err=1 valid=00", rsp_err, rsp_valid);
        end
        tx_full = 4'b0000;
        exp_ptr = 1;
    endtask

    task automatic test_nop();
        int n;
        int s0;
        pio_dout = 32'h0BAD_F00D;
        set_req(1, ACT_NONE, 2'd1, 5'd9, 32'h1111_2222);
        expect_cmd(1, ACT_NONE, 2'd1, 5'd9, 32'h1111_2222, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0);
        s0 = stb_cnt;
        req_valid = 2'b10;
        wait_ready(20, n);
        req_valid = 2'b00;
        wait_rsp(20);
        checks++;
        if (last_rsp_cyc != n + 4 || stb_cnt != s0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL nop_cmd: got rsp@+%0d strobes=%0d err=%b, expected +4, 0, 0",
                     last_rsp_cyc - n, stb_cnt - s0, rsp_err);
        end
        exp_ptr = 0;
    endtask

    task automatic test_back_to_back();
        int n;
        int prev;
        int g[4];
        logic [1:0] want;
        pio_dout = 32'h55AA_55AA;
        set_req(0, ACT_PUSH, 2'd0, 5'd2, 32'h1000_0000);
        set_req(1, ACT_PULL, 2'd1, 5'd4, 32'h2000_0000);
        for (int k = 0; k < 4; k++) begin
`ifdef PIO_ARB_FIXED_PRIO_EN
            g[k] = 0;
`else
            g[k] = (exp_ptr + k) % 2;
`endif
            if (g[k] == 0)
                expect_cmd(0, ACT_PUSH, 2'd0, 5'd2, 32'h1000_0000, 1'b0, 1'b1, 32'h55AA_55AA, 1'b1);
            else
                expect_cmd(1, ACT_PULL, 2'd1, 5'd4, 32'h2000_0000, 1'b0, 1'b1, 32'h55AA_55AA, 1'b1);
        end
        prev = 0;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ready(20, n);
            want = 2'b01 << g[k];
            checks++;
            if (last_ready !== want) begin
                errors++;
                $display("FAIL grant_order_%0d: got ready=%b, expected %b", k, last_ready, want);
            end
            if (k > 0) begin
                checks++;
                if (n - prev != 5) begin
                    errors++;
                    $display("FAIL accept_rate_%0d: got %0d cycles between accepts, expected 5", k, n - prev);
                end
            end
            prev = n;
            wait_rsp(20);
        end
        req_valid = 2'b00;
`ifdef PIO_ARB_FIXED_PRIO_EN
        exp_ptr = 0;
`else
        exp_ptr = (g[3] + 1) % 2;
`endif
    endtask

    task automatic test_reset_mid();
        int n;
        int r0;
        tx_full = 4'b1000;
        set_req(0, ACT_PUSH, 2'd3, 5'd5, 32'h0F0F_0F0F);
        req_valid = 2'b01;
        wait_ready(20, n);
        req_valid = 2'b00;
        repeat (3) tick();
        r0 = rsp_cnt;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_dout, pio_action, pio_mindex, pio_index, pio_din} !== 80'd0) begin
            errors++;
            $display("FAIL async_reset: got mindex=%0d idx=%0d din=%h dout=%h err=%b, expected all 0",
                     pio_mindex, pio_index, pio_din, rsp_dout, rsp_err);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tx_full = 4'b0000;
        repeat (2) tick();
        checks++;
        if (rsp_cnt != r0) begin
            errors++;
            $display("FAIL reset_no_rsp: got %0d responses for aborted command, expected 0", rsp_cnt - r0);
        end
        exp_ptr = 0;
        pio_dout = 32'h7777_0000;
        set_req(0, ACT_PUSH, 2'd2, 5'd6, 32'h0000_0077);
        set_req(1, ACT_PULL, 2'd0, 5'd8, 32'h0000_0088);
        expect_cmd(0, ACT_PUSH, 2'd2, 5'd6, 32'h0000_0077, 1'b0, 1'b1, 32'h7777_0000, 1'b1);
        req_valid = 2'b11;
        wait_ready(20, n);
        req_valid = 2'b00;
        checks++;
        if (last_ready !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_grant: got ready=%b, expected 01", last_ready);
        end
        wait_rsp(20);
        checks++;
        if (last_rsp_cyc != n + 4) begin
            errors++;
            $display("FAIL post_reset_latency: got rsp@+%0d, expected +4", last_rsp_cyc - n);
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_pull_stall();
        test_timeout();
        test_nop();
        test_back_to_back();
        test_reset_mid();
        repeat (4) tick();
        checks++;
        if (rsp_q.size() != 0 || stb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d rsp and %0d strobes outstanding, expected 0",
                     rsp_q.size(), stb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
